// File: rtl/gpio_pkg.sv
// Shared register map offsets, bus sizing and the interrupt type encoding for the GPIO IRQ block.
package gpio_pkg;

  localparam int unsigned BUS_AW = 8;
  localparam int unsigned BUS_DW = 32;

  localparam logic [BUS_AW-1:0] GPIO_IRQ_SYNC    = 8'h00;
  localparam logic [BUS_AW-1:0] GPIO_IRQ_EN      = 8'h04;
  localparam logic [BUS_AW-1:0] GPIO_IRQ_TYPE    = 8'h08;
  localparam logic [BUS_AW-1:0] GPIO_IRQ_POL     = 8'h0C;
  localparam logic [BUS_AW-1:0] GPIO_IRQ_PENDING = 8'h10;
  localparam logic [BUS_AW-1:0] GPIO_IRQ_DEBCNT  = 8'h14;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_type_e;

endpackage

// File: rtl/slave_bus_if.sv
// Simple single-cycle register bus: select, write enable, byte address, 32-bit data both ways.
interface slave_bus_if;
  logic        ss;
  logic        wen;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport slave  (input ss, wen, addr, wdata, output rdata, bdone);
  modport master (output ss, wen, addr, wdata, input rdata, bdone);
endinterface

// File: rtl/gpio_debounce.sv
// Per-bit stability filter: output follows input once it has held for limit+1 cycles.
// Only built when GPIO_IRQ_DEBOUNCE_EN is defined.
`ifdef GPIO_IRQ_DEBOUNCE_EN
module gpio_debounce #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEB_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [DEB_W-1:0] limit,
  output logic [WIDTH-1:0] dout
);

  logic [DEB_W-1:0] cnt [WIDTH];

  // A bit counts only while it differs from the forwarded value; returning to it restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (din[i] == dout[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == limit) begin
          dout[i] <= din[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/gpio_irq_wrapped.sv
// GPIO pin interrupt controller: synchronizer, edge/level pending logic, register file, irq.
// Optional debounce filter enabled with GPIO_IRQ_DEBOUNCE_EN.
module gpio_irq_wrapped
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEB_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  slave_bus_if.slave       bus,
  input  logic [WIDTH-1:0] pins_in,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, det, prev;
  logic [WIDTH-1:0] en, typ, pol, pending, pending_nxt;
  logic             we;
  logic [DEB_W-1:0] deb_cnt;
  logic             unused_wdata;

  assign we           = bus.ss && bus.wen;
  assign bus.bdone    = 1'b1;
  assign unused_wdata = ^bus.wdata[BUS_DW-1:WIDTH];

  // Two-flop synchronizer on the raw pin levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_cnt <= '0;
    else if (we && bus.addr == GPIO_IRQ_DEBCNT) deb_cnt <= bus.wdata[DEB_W-1:0];
  end

  gpio_debounce #(.WIDTH(WIDTH), .DEB_W(DEB_W)) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync2),
    .limit (deb_cnt),
    .dout  (det)
  );
`else
  assign deb_cnt = '0;
  assign det     = sync2;
`endif

  // Configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= '0;
      typ <= '0;
      pol <= '0;
    end else if (we) begin
      case (bus.addr)
        GPIO_IRQ_EN:   en  <= bus.wdata[WIDTH-1:0];
        GPIO_IRQ_TYPE: typ <= bus.wdata[WIDTH-1:0];
        GPIO_IRQ_POL:  pol <= bus.wdata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Edge bits are sticky with W1C (a fresh edge beats a clear); level bits track the pin.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (irq_type_e'(typ[i]) == IRQ_EDGE) begin
        pending_nxt[i] = ((det[i] != prev[i]) && (det[i] == pol[i])) ||
                         (pending[i] && !(we && bus.addr == GPIO_IRQ_PENDING && bus.wdata[i]));
      end else begin
        pending_nxt[i] = (det[i] == pol[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      prev    <= det;
      pending <= pending_nxt;
      irq     <= |(pending & en);
    end
  end

  // Combinational read mux; unmapped offsets return zero.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      GPIO_IRQ_SYNC:    bus.rdata = BUS_DW'(sync2);
      GPIO_IRQ_EN:      bus.rdata = BUS_DW'(en);
      GPIO_IRQ_TYPE:    bus.rdata = BUS_DW'(typ);
      GPIO_IRQ_POL:     bus.rdata = BUS_DW'(pol);
      GPIO_IRQ_PENDING: bus.rdata = BUS_DW'(pending);
      GPIO_IRQ_DEBCNT:  bus.rdata = BUS_DW'(deb_cnt);
      default:          bus.rdata = '0;
    endcase
  end

endmodule

// File: doc/gpio_irq_wrapped.md
GPIO_IRQ_WRAPPED -- requirements
Module: gpio_irq_wrapped

Interface
REQ-001 Parameter: WIDTH, 8, number of pin inputs monitored (1..8).
REQ-002 Parameter: DEB_W, 8, debounce counter width in bits (used only with GPIO_IRQ_DEBOUNCE_EN).
REQ-003 Port: clk  input  1  single clock; all state on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: bus  slave_bus_if.slave  -  register access through ss, wen, addr[7:0], wdata, rdata, bdone.
REQ-006 Port: pins_in  input  WIDTH  asynchronous pin levels taken from the gpio_wrapped pin net.
REQ-007 Port: irq  output  1  level interrupt request to the core, active-high.

Function
REQ-010 The block SHALL pass pins_in through a 2-flop synchronizer; sync value = second stage.
REQ-011 The block SHALL hold a prev register (sync delayed one cycle) for edge detection.
REQ-012 Register map (byte offsets, 32-bit data, upper bits read 0): 0x00 SYNC (RO), 0x04 IRQ_EN, 0x08 IRQ_TYPE (1=edge, 0=level), 0x0C IRQ_POL (1=high/rising, 0=low/falling), 0x10 PENDING (W1C), 0x14 DEB_CNT (RW when GPIO_IRQ_DEBOUNCE_EN defined, else reads 0).
REQ-013 Reads SHALL be combinational on bus.addr[7:0]; unmapped offsets SHALL read 0.
REQ-014 Writes SHALL commit on posedge clk when bus.ss && bus.wen; writes to RO/unmapped offsets SHALL be ignored.
REQ-015 bus.bdone SHALL be constant 1 (single-cycle access).
REQ-016 Edge bit i: pending[i] SHALL set the cycle after sync[i] != prev[i] with sync[i] == IRQ_POL[i].
REQ-017 Level bit i: pending[i] SHALL equal (sync[i] == IRQ_POL[i]) registered, ignoring W1C.
REQ-018 Edge pending bits SHALL stay set until W1C with wdata[i]=1 at offset 0x10.
REQ-019 Same-cycle edge detect and W1C on one bit: set SHALL win.
REQ-020 Pending SHALL be latched regardless of IRQ_EN; enabling a pending bit SHALL raise irq next cycle.
REQ-021 irq SHALL be registered: irq <= |(pending & IRQ_EN), one cycle after pending changes.
REQ-022 Changing IRQ_TYPE from edge to level SHALL reload pending[i] from level rule next cycle.
REQ-023 Pin-change to irq latency (debounce off): 4 cycles (2 sync, 1 pending, 1 irq).

Reset
REQ-030 On rst_n low, asynchronously: sync stages, prev, IRQ_EN, IRQ_TYPE, IRQ_POL, PENDING, irq = 0; DEB_CNT = 0.
REQ-031 Reset mid-operation SHALL drop irq immediately and discard all pending events; first edge after release is detected against prev=0.

Configuration
REQ-040 Macro GPIO_IRQ_DEBOUNCE_EN defined: per-bit counter of DEB_W bits; sync[i] SHALL be forwarded to the edge/level logic only after it has been stable for DEB_CNT+1 consecutive cycles; counter restarts on any change; DEB_CNT=0 means one-cycle stability (adds 1 cycle latency).
REQ-041 Macro undefined: no counters instantiated; sync feeds detection directly; offset 0x14 reads 0, writes ignored.

Structure
REQ-050 Shared package gpio_pkg SHALL hold register offset localparams (GPIO_IRQ_SYNC..GPIO_IRQ_DEBCNT) and the irq_type_e enum (IRQ_LEVEL, IRQ_EDGE).
REQ-051 One sub-module gpio_debounce (per-bit stable counter, WIDTH-wide) SHALL be instantiated only under GPIO_IRQ_DEBOUNCE_EN.

Verification
REQ-060 Reset then read 0x00..0x14 -> all 0, irq=0, bdone=1.
REQ-061 IRQ_EN=0x01, TYPE=0x01, POL=0x01; pins_in[0] 0->1 -> PENDING=0x01 at cycle 3, irq=1 at cycle 4; write 0x01 to 0x10 -> PENDING=0, irq=0 next cycle.
REQ-062 Level, POL=0 on bit 2, EN=0x04: pins_in[2]=0 -> irq=1; W1C 0x04 -> pending remains 1; pins_in[2]=1 -> irq drops 4 cycles later.
REQ-063 Edge bit 0 rising and W1C 0x01 in the same cycle -> PENDING[0] remains 1.
REQ-064 EN=0, rising edge on bit 5 -> PENDING=0x20, irq=0; then EN=0x20 -> irq=1 next cycle.
REQ-065 (GPIO_IRQ_DEBOUNCE_EN) DEB_CNT=3: 2-cycle glitch on bit 1 -> no pending; 6-cycle pulse -> PENDING[1]=1.
